// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: opcodes, FSM states,
// ALU-op triples, mux select codes and the control-word payload.
package multicycle_ctrl_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEN   = 6'b010100;
  localparam logic [OPC_W-1:0] OP_BVF   = 6'b010101;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_AEXEC  = 4'd8,
    S_AWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_BEN    = 4'd11,
    S_BVF    = 4'd12,
    S_JUMP   = 4'd13
  } state_e;

  // {aluop1,aluop2,aluop3} codes seen by the ALU control decoder
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_RTYPE = 3'b100;
  localparam logic [2:0] ALU_BEN   = 3'b110;
  localparam logic [2:0] ALU_BVF   = 3'b001;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_4        = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pc_source;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; flags the cycle in which the
// stall length reaches MEM_TMO.
module mem_wait_timer #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q holds the stalls already seen, so this stall is number cnt_q+1
  assign expired = en && (cnt_q == CNT_W'(MEM_TMO - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/memory/
// writeback, stalls on mem_ready and aborts memory accesses that never complete.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned MEM_TMO = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pc_source,
  output logic            aluop1,
  output logic            aluop2,
  output logic            aluop3,
  output logic            illegal_op,
  output logic            mem_fault
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_wait, tmr_en, tmr_clr, expired, fault, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall timer runs only while a memory request is outstanding and unanswered
  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign tmr_en   = mem_wait && !mem_ready;
  assign fault    = tmr_en && expired;
  assign tmr_clr  = fault || (state_d != state_q);

  mem_wait_timer #(
    .CNT_W  (CNT_W),
    .MEM_TMO(MEM_TMO)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .expired(expired)
  );

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alusrcb   = SRCB_4;
        ctrl.aluop     = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_SEXT_SH2;
        case (opcode)
          OP_W'(OP_LW), OP_W'(OP_SW): state_d = S_MEMADR;
          OP_W'(OP_RTYPE):            state_d = S_REXEC;
          OP_W'(OP_BEQ):              state_d = S_BEQ;
          OP_W'(OP_BEN):              state_d = S_BEN;
          OP_W'(OP_BVF):              state_d = S_BVF;
          OP_W'(OP_ADDI):             state_d = S_AEXEC;
          OP_W'(OP_J):                state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_SEXT;
        state_d      = (opcode == OP_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_REXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_RTYPE;
        state_d      = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_AEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_SEXT;
        state_d      = S_AWB;
      end
      S_AWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_BEQ, S_BEN, S_BVF: begin
        ctrl.alusrca       = 1'b1;
        ctrl.alusrcb       = SRCB_B;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.aluop         = (state_q == S_BEQ) ? ALU_SUB :
                             (state_q == S_BEN) ? ALU_BEN : ALU_BVF;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Timeout abandons the access: request dropped this cycle, restart at fetch
    if (fault) begin
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      state_d        = S_FETCH;
    end
    if (!rst_n) begin
      ctrl    = '0;
      illegal = 1'b0;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alusrca       = ctrl.alusrca;
  assign alusrcb       = ctrl.alusrcb;
  assign pc_source     = ctrl.pc_source;
  assign aluop1        = ctrl.aluop[2];
  assign aluop2        = ctrl.aluop[1];
  assign aluop3        = ctrl.aluop[0];
  assign illegal_op    = illegal;
  assign mem_fault     = fault && rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios with literal expectations, then
// random opcodes/mem_ready checked every cycle against a microprogram-queue model.
module tb_multicycle_ctrl;

  localparam int MEM_TMO = 15;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BEN = 6'b010100, OP_BVF = 6'b010101;

  // Control word bit weights, MSB first in port order
  localparam logic [16:0] PCW = 17'h10000, PCWC = 17'h08000, IORD = 17'h04000,
                          MR = 17'h02000, MW = 17'h01000, IRW = 17'h00800,
                          M2R = 17'h00400, RDST = 17'h00200, RW = 17'h00100,
                          ASA = 17'h00080;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_ready = 1'b0;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic reg_dst, reg_write, alusrca, aluop1, aluop2, aluop3, illegal_op, mem_fault;
  logic [1:0] alusrcb, pc_source;
  logic [16:0] ctl;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alusrca(alusrca), .alusrcb(alusrcb), .pc_source(pc_source),
    .aluop1(aluop1), .aluop2(aluop2), .aluop3(aluop3),
    .illegal_op(illegal_op), .mem_fault(mem_fault)
  );

  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alusrca, alusrcb, pc_source, aluop1, aluop2, aluop3};

  function automatic logic [16:0] asb(input logic [1:0] v); return {10'd0, v, 5'd0}; endfunction
  function automatic logic [16:0] pcs(input logic [1:0] v); return {12'd0, v, 3'd0}; endfunction
  function automatic logic [16:0] aop(input logic [2:0] v); return {14'd0, v}; endfunction

  // ---------------- behavioural model: each instruction expands to a step list
  typedef struct packed {
    logic [16:0] ctl;
    logic [16:0] extra;   // bits added in a cycle where mem_ready=1
    logic        mem;     // step waits on mem_ready
    logic        fetch;
    logic        dec;
  } step_t;

  step_t m_cur;
  step_t m_prog[$];
  int    m_waited;

  function automatic step_t st(input logic [16:0] c, input logic m);
    step_t s;
    s = '0; s.ctl = c; s.mem = m;
    return s;
  endfunction

  function automatic step_t st_fetch();
    step_t s;
    s = '0; s.ctl = MR | asb(2'b01); s.extra = IRW | PCW; s.mem = 1'b1; s.fetch = 1'b1;
    return s;
  endfunction

  function automatic step_t st_decode();
    step_t s;
    s = '0; s.ctl = asb(2'b11); s.dec = 1'b1;
    return s;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BEN, OP_BVF};
  endfunction

  function automatic void load_prog(input logic [5:0] op);
    case (op)
      OP_LW: begin
        m_prog.push_back(st(ASA | asb(2'b10), 1'b0));
        m_prog.push_back(st(IORD | MR, 1'b1));
        m_prog.push_back(st(RW | M2R, 1'b0));
      end
      OP_SW: begin
        m_prog.push_back(st(ASA | asb(2'b10), 1'b0));
        m_prog.push_back(st(IORD | MW, 1'b1));
      end
      OP_R: begin
        m_prog.push_back(st(ASA | aop(3'b100), 1'b0));
        m_prog.push_back(st(RW | RDST, 1'b0));
      end
      OP_ADDI: begin
        m_prog.push_back(st(ASA | asb(2'b10), 1'b0));
        m_prog.push_back(st(RW, 1'b0));
      end
      OP_BEQ: m_prog.push_back(st(ASA | PCWC | pcs(2'b01) | aop(3'b010), 1'b0));
      OP_BEN: m_prog.push_back(st(ASA | PCWC | pcs(2'b01) | aop(3'b110), 1'b0));
      OP_BVF: m_prog.push_back(st(ASA | PCWC | pcs(2'b01) | aop(3'b001), 1'b0));
      OP_J:   m_prog.push_back(st(PCW | pcs(2'b10), 1'b0));
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur = st_fetch();
      m_prog.delete();
      m_waited = 0;
    end else if (m_cur.mem && !mem_ready) begin
      m_waited++;
      if (m_waited >= MEM_TMO) begin
        m_cur = st_fetch();
        m_prog.delete();
        m_waited = 0;
      end
    end else begin
      m_waited = 0;
      if (m_cur.fetch) m_prog.push_back(st_decode());
      else if (m_cur.dec) load_prog(opcode);
      m_cur = (m_prog.size() > 0) ? m_prog.pop_front() : st_fetch();
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [18:0] e;
    e = '0;
    if (rst_n) begin
      e[18:2] = m_cur.ctl | (mem_ready ? m_cur.extra : 17'd0);
      e[1]    = m_cur.dec && !is_legal(opcode);
      e[0]    = m_cur.mem && !mem_ready && (m_waited + 1 == MEM_TMO);
      if (e[0]) begin
        e[15] = 1'b0;
        e[14] = 1'b0;
      end
    end
    n_tests++;
    if ({ctl, illegal_op, mem_fault} !== e) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t op=%b rdy=%b got %05h expected %05h",
               $time, opcode, mem_ready, {ctl, illegal_op, mem_fault}, e);
    end
  end

  // ---------------- directed helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy);
    @(posedge clk);
    #2;
    opcode = op;
    mem_ready = rdy;
    #4;
  endtask

  logic [16:0] trace[16];
  logic        ill_tr[16];
  int          lat;

  // Runs one instruction from FETCH with mem_ready=1, records control words
  // until the next FETCH is seen, and parks there with mem_ready=0.
  task automatic run_instr(input logic [5:0] op);
    lat = 99;
    step(op, 1'b1);
    trace[0] = ctl;
    ill_tr[0] = illegal_op;
    for (int i = 1; i < 16; i++) begin
      @(posedge clk);
      #2;
      if (mem_read && !iord) begin
        lat = i;
        mem_ready = 1'b0;
        #4;
        break;
      end
      mem_ready = 1'b1;
      #4;
      trace[i] = ctl;
      ill_tr[i] = illegal_op;
    end
  endtask

  logic [5:0] legal_ops[8] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BEN, OP_BVF};

  initial begin
    int fault_at, nf, stall;
    logic [2:0] aop_or;

    #11;
    chk("reset_outputs_zero", {13'd0, ctl, illegal_op, mem_fault}, 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("fetch_after_reset", ctl, 17'b00010000000100000);

    run_instr(OP_LW);
    chk("lw_latency", lat, 5);
    chk("lw_writeback", trace[4] & (RW | M2R | RDST), RW | M2R);
    aop_or = 3'b000;
    for (int i = 0; i < 5; i++) aop_or = aop_or | trace[i][2:0];
    chk("lw_aluop_add", aop_or, 3'b000);

    run_instr(OP_R);
    chk("rtype_latency", lat, 4);
    chk("rtype_aluop", trace[2][2:0], 3'b100);
    chk("rtype_wb", trace[3] & (RW | RDST | M2R), RW | RDST);

    run_instr(OP_SW);
    chk("sw_latency", lat, 4);
    run_instr(OP_ADDI);
    chk("addi_latency", lat, 4);

    run_instr(OP_BEN);
    chk("ben_latency", lat, 3);
    chk("ben_cycle3", trace[2] & (PCWC | pcs(2'b11) | aop(3'b111)), PCWC | pcs(2'b01) | aop(3'b110));
    run_instr(OP_BVF);
    chk("bvf_cycle3", trace[2] & (PCWC | pcs(2'b11) | aop(3'b111)), PCWC | pcs(2'b01) | aop(3'b001));
    run_instr(OP_J);
    chk("j_latency", lat, 3);
    chk("j_cycle3", trace[2] & (PCW | pcs(2'b11)), PCW | pcs(2'b10));

    run_instr(6'b111111);
    chk("illegal_latency", lat, 2);
    chk("illegal_pulse", ill_tr[1], 1'b1);
    chk("illegal_next_fetch", ctl & (RW | PCW | MR), MR);

    // SW stalled for MEM_TMO cycles must fault on the last one
    step(OP_SW, 1'b1); step(OP_SW, 1'b1); step(OP_SW, 1'b1);
    fault_at = 0;
    for (int k = 1; k <= 16 && fault_at == 0; k++) begin
      step(OP_SW, 1'b0);
      if (mem_fault) fault_at = k;
    end
    chk("sw_timeout_cycle", fault_at, 15);
    step(OP_SW, 1'b0);
    chk("fault_back_to_fetch", {mem_read, iord, mem_write, pc_write}, 4'b1000);

    // Ready arriving on the timeout cycle wins
    step(OP_SW, 1'b1); step(OP_SW, 1'b1); step(OP_SW, 1'b1);
    nf = 0;
    for (int k = 1; k <= 15; k++) begin
      step(OP_SW, k == 15);
      if (mem_fault) nf++;
    end
    chk("ready_on_timeout_no_fault", nf, 0);
    step(OP_SW, 1'b0);
    chk("ready_on_timeout_fetch", {mem_read, iord}, 2'b10);

    // Reset asserted in the middle of a stalled load
    step(OP_LW, 1'b1); step(OP_LW, 1'b1); step(OP_LW, 1'b1);
    step(OP_LW, 1'b0); step(OP_LW, 1'b0);
    chk("memrd_active", {mem_read, iord}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_drops_mem_read", {13'd0, ctl, illegal_op, mem_fault}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("fetch_after_midreset", {mem_read, iord, mem_write, ir_write}, 4'b1000);

    // Random traffic, opcode only changed while fetching
    stall = 0;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #2;
      if (m_cur.fetch)
        opcode = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(0, 39) == 0) stall = int'($urandom_range(8, 18));
        mem_ready = ($urandom_range(0, 3) != 0);
      end
    end

    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
